// File: rtl/aibnd_ioload_pkg.sv
// Shared types and helpers for the strobe-path dummy IO load trim sequencer.
package aibnd_ioload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_STEP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } ioload_st_t;

  typedef enum logic {
    OWN_CAL = 1'b0,
    OWN_OVR = 1'b1
  } ioload_own_t;

  // Requested segment counts above the number of physical segments saturate.
  function automatic int unsigned clamp_code(input int unsigned code,
                                             input int unsigned nseg);
    return (code > nseg) ? nseg : code;
  endfunction

endpackage

// File: rtl/aibnd_ioload_therm.sv
// Binary segment count to thermometer enable decoder (purely combinational).
module aibnd_ioload_therm #(
  parameter  int NSEG = 8,
  localparam int CW   = $clog2(NSEG + 1)
) (
  input  logic [CW-1:0]   code_i,
  output logic [NSEG-1:0] therm_o
);

  always_comb begin
    therm_o = '0;
    for (int i = 0; i < NSEG; i++) begin
      therm_o[i] = (i < int'(code_i));
    end
  end

endmodule

// File: rtl/aibnd_str_ioload_ctl.sv
// Load-trim sequencer: walks a thermometer enable bus one segment at a time
// toward a calibration or override target, with a programmable settle gap.
module aibnd_str_ioload_ctl
  import aibnd_ioload_pkg::*;
#(
  parameter  int NSEG     = 8,
  parameter  int SETTLE_W = 4,
  localparam int CW       = $clog2(NSEG + 1)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                cal_req,
  input  logic [CW-1:0]       cal_code,
  output logic                cal_ack,
  input  logic                ovr_en,
  input  logic [CW-1:0]       ovr_code,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic [NSEG-1:0]     load_en,
  output logic [CW-1:0]       cur_code,
  output logic                busy,
  output ioload_st_t          dbg_state
);

  localparam int unsigned NSEG_U = NSEG;

  // Handshake: cal_req is a level held with cal_code stable until a single
  // cycle cal_ack pulse; dropping cal_req early abandons the request unacked.

  ioload_st_t          state_q, state_d;
  ioload_own_t         owner_q, owner_d;
  logic [CW-1:0]       target_q, target_d;
  logic [CW-1:0]       cur_code_q, cur_code_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [NSEG-1:0]     load_en_q, therm_d;
  logic                cal_ack_q, ack_d;
  logic                busy_q;

  logic [CW-1:0]       cal_tgt, ovr_tgt, step_code, dec_code, dec_target;
  ioload_st_t          dec_state;
  ioload_own_t         dec_owner;

  assign cal_tgt   = CW'(clamp_code(32'(cal_code), NSEG_U));
  assign ovr_tgt   = CW'(clamp_code(32'(ovr_code), NSEG_U));
  assign step_code = (cur_code_q < target_q) ? cur_code_q + CW'(1)
                                             : cur_code_q - CW'(1);
  assign dec_code  = (state_q == ST_STEP) ? step_code : cur_code_q;

  // Step decision: override preempts a calibration owner, a withdrawn
  // calibration request abandons in place, otherwise continue or finish.
  always_comb begin
    dec_owner  = owner_q;
    dec_target = target_q;
    dec_state  = ST_STEP;
    if (owner_q == OWN_CAL && ovr_en) begin
      dec_owner  = OWN_OVR;
      dec_target = ovr_tgt;
    end
    if (owner_q == OWN_CAL && !ovr_en && !cal_req) begin
      dec_state = ST_IDLE;
    end else if (dec_code == dec_target) begin
      dec_state = ST_DONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    target_d   = target_q;
    cur_code_d = cur_code_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ovr_en) begin
          state_d = ST_GRANT;
          owner_d = OWN_OVR;
        end else if (cal_req) begin
          state_d = ST_GRANT;
          owner_d = OWN_CAL;
        end
      end
      ST_GRANT: begin
        target_d = (owner_q == OWN_OVR) ? ovr_tgt : cal_tgt;
        state_d  = (cur_code_q == target_d) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        cur_code_d = step_code;
        if (settle_cyc == '0) begin
          state_d  = dec_state;
          owner_d  = dec_owner;
          target_d = dec_target;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = settle_cyc;
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= SETTLE_W'(1)) begin
          state_d  = dec_state;
          owner_d  = dec_owner;
          target_d = dec_target;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      ST_DONE: begin
        ack_d   = (owner_q == OWN_CAL);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  aibnd_ioload_therm #(.NSEG(NSEG)) u_therm (
    .code_i  (cur_code_d),
    .therm_o (therm_d)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_CAL;
      target_q   <= '0;
      cur_code_q <= '0;
      cnt_q      <= '0;
      load_en_q  <= '0;
      cal_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      target_q   <= target_d;
      cur_code_q <= cur_code_d;
      cnt_q      <= cnt_d;
      load_en_q  <= therm_d;
      cal_ack_q  <= ack_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign load_en   = load_en_q;
  assign cur_code  = cur_code_q;
  assign cal_ack   = cal_ack_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aibnd_str_ioload_ctl.sv
// Directed bench for the IO load trim sequencer (NSEG=8, SETTLE_W=4).
module tb_aibnd_str_ioload_ctl;
  import aibnd_ioload_pkg::*;

  logic       clk = 1'b0;
  logic       rstb;
  logic       cal_req;
  logic [3:0] cal_code;
  logic       cal_ack;
  logic       ovr_en;
  logic [3:0] ovr_code;
  logic [3:0] settle_cyc;
  logic [7:0] load_en;
  logic [3:0] cur_code;
  logic       busy;
  ioload_st_t dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  aibnd_str_ioload_ctl #(.NSEG(8), .SETTLE_W(4)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .cal_req    (cal_req),
    .cal_code   (cal_code),
    .cal_ack    (cal_ack),
    .ovr_en     (ovr_en),
    .ovr_code   (ovr_code),
    .settle_cyc (settle_cyc),
    .load_en    (load_en),
    .cur_code   (cur_code),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rstb = 1'b0; cal_req = 1'b0; cal_code = '0;
    ovr_en = 1'b0; ovr_code = '0; settle_cyc = '0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  // cyc = cycles after the granting edge T0 at which cal_ack was seen, -1 if never
  task automatic wait_ack(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (cal_ack === 1'b1) begin
        cyc = i - 1;
        break;
      end
    end
  endtask

  task automatic wait_code(input logic [3:0] v, input int max_cyc,
                           output bit ok, output bit ack_seen);
    ok = 1'b0; ack_seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (cal_ack === 1'b1) ack_seen = 1'b1;
      if (cur_code === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; cal_req = 1'b0; cal_code = '0;
    ovr_en = 1'b0; ovr_code = '0; settle_cyc = '0;
    #1;
    tests_run++;
    if (load_en !== 8'h00 || cur_code !== 4'd0 || busy !== 1'b0 ||
        cal_ack !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset: load_en=%h cur=%0d busy=%b ack=%b st=%0d, required 00/0/0/0/0",
               load_en, cur_code, busy, cal_ack, dbg_state);
    end
    do_reset();
  endtask

  task automatic test_ramp_s0();
    logic [7:0] exp_le [8] = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    do_reset();
    settle_cyc = 4'd0; cal_code = 4'd5; cal_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ramp_busy: busy=%b required 1", busy);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      tests_run++;
      if (load_en !== exp_le[k] || cal_ack !== (k == 7)) begin
        tests_failed++;
        $display("FAIL ramp_s0 k=%0d: load_en=%h ack=%b, required %h/%b",
                 k, load_en, cal_ack, exp_le[k], (k == 7));
      end
    end
    cal_req = 1'b0;
    tests_run++;
    if (cur_code !== 4'd5) begin
      tests_failed++;
      $display("FAIL ramp_code: cur=%0d required 5", cur_code);
    end
    @(negedge clk);
    tests_run++;
    if (cal_ack !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ramp_after: ack=%b busy=%b required 0/0", cal_ack, busy);
    end
  endtask

  task automatic test_settle();
    logic [3:0] up [11] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2};
    logic [3:0] dn [11] = '{2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    do_reset();
    settle_cyc = 4'd3; cal_code = 4'd2; cal_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (cur_code !== up[k] || cal_ack !== (k == 10)) begin
        tests_failed++;
        $display("FAIL settle_up k=%0d: cur=%0d ack=%b, required %0d/%b",
                 k, cur_code, cal_ack, up[k], (k == 10));
      end
    end
    tests_run++;
    if (load_en !== 8'h03) begin
      tests_failed++;
      $display("FAIL settle_up_le: load_en=%h required 03", load_en);
    end
    cal_req = 1'b0; cal_code = 4'd0;
    @(negedge clk);
    cal_req = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (cur_code !== dn[k] || cal_ack !== (k == 10)) begin
        tests_failed++;
        $display("FAIL settle_dn k=%0d: cur=%0d ack=%b, required %0d/%b",
                 k, cur_code, cal_ack, dn[k], (k == 10));
      end
      if (k == 3) begin
        tests_run++;
        if (load_en !== 8'h01) begin
          tests_failed++;
          $display("FAIL settle_dn_le: load_en=%h required 01", load_en);
        end
      end
    end
    cal_req = 1'b0;
    tests_run++;
    if (load_en !== 8'h00) begin
      tests_failed++;
      $display("FAIL settle_dn_end: load_en=%h required 00", load_en);
    end
    @(negedge clk);
  endtask

  task automatic test_clamp();
    int cyc;
    do_reset();
    settle_cyc = 4'd0; cal_code = 4'd12; cal_req = 1'b1;
    wait_ack(30, cyc);
    tests_run++;
    if (cyc != 10 || load_en !== 8'hFF || cur_code !== 4'd8) begin
      tests_failed++;
      $display("FAIL clamp: ack_cyc=%0d load_en=%h cur=%0d, required 10/FF/8",
               cyc, load_en, cur_code);
    end
    cal_req = 1'b0;
    @(negedge clk);
    cal_code = 4'd8; cal_req = 1'b1;
    wait_ack(10, cyc);
    tests_run++;
    if (cyc != 2 || load_en !== 8'hFF) begin
      tests_failed++;
      $display("FAIL zero_step: ack_cyc=%0d load_en=%h, required 2/FF", cyc, load_en);
    end
    cal_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preempt();
    logic [3:0] exp_c [13] = '{0, 0, 1, 2, 3, 2, 1, 1, 1, 1, 1, 1, 1};
    int cyc;
    do_reset();
    settle_cyc = 4'd0; cal_code = 4'd6; cal_req = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      tests_run++;
      if (cur_code !== exp_c[k] || cal_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL preempt k=%0d: cur=%0d ack=%b, required %0d/0",
                 k, cur_code, cal_ack, exp_c[k]);
      end
      if (k == 3) begin
        ovr_en = 1'b1; ovr_code = 4'd1;
      end
    end
    ovr_en = 1'b0;
    wait_ack(40, cyc);
    tests_run++;
    if (cyc < 0 || cur_code !== 4'd6 || load_en !== 8'h3F) begin
      tests_failed++;
      $display("FAIL preempt_resume: ack_cyc=%0d cur=%0d load_en=%h, required ack/6/3F",
               cyc, cur_code, load_en);
    end
    cal_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, acks;
    int cyc;
    do_reset();
    settle_cyc = 4'd3; cal_code = 4'd6; cal_req = 1'b1;
    wait_code(4'd4, 40, ok, acks);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: cur=%0d required 4", cur_code);
    end
    @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    tests_run++;
    if (load_en !== 8'h00 || cur_code !== 4'd0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL rst_mid_async: load_en=%h cur=%0d busy=%b st=%0d, required 00/0/0/0",
               load_en, cur_code, busy, dbg_state);
    end
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      tests_run++;
      if (cur_code !== ((k == 2) ? 4'd1 : 4'd0) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_mid_restart k=%0d: cur=%0d busy=%b, required %0d/1",
                 k, cur_code, busy, (k == 2));
      end
    end
    wait_ack(60, cyc);
    tests_run++;
    if (cyc < 0 || cur_code !== 4'd6) begin
      tests_failed++;
      $display("FAIL rst_mid_ack: ack_cyc=%0d cur=%0d, required ack/6", cyc, cur_code);
    end
    cal_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abandon();
    bit ok, acks;
    do_reset();
    settle_cyc = 4'd2; cal_code = 4'd6; cal_req = 1'b1;
    wait_code(4'd3, 40, ok, acks);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL abandon_reach: cur=%0d required 3", cur_code);
    end
    cal_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests_run++;
      if (cal_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL abandon_ack k=%0d: ack=%b required 0", k, cal_ack);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || load_en !== 8'h07 || cur_code !== 4'd3 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL abandon_hold: busy=%b load_en=%h cur=%0d st=%0d, required 0/07/3/0",
               busy, load_en, cur_code, dbg_state);
    end
  endtask

  task automatic test_ovr_track();
    bit ok, acks;
    settle_cyc = 4'd0; ovr_code = 4'd3; ovr_en = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (cur_code !== 4'd3) begin
      tests_failed++;
      $display("FAIL ovr_hold: cur=%0d required 3", cur_code);
    end
    ovr_code = 4'd15;
    wait_code(4'd8, 30, ok, acks);
    tests_run++;
    if (!ok || acks || load_en !== 8'hFF) begin
      tests_failed++;
      $display("FAIL ovr_track: reached=%b ack_seen=%b load_en=%h, required 1/0/FF",
               ok, acks, load_en);
    end
    ovr_en = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || cur_code !== 4'd8) begin
      tests_failed++;
      $display("FAIL ovr_release: busy=%b cur=%0d, required 0/8", busy, cur_code);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_s0();
    test_settle();
    test_clamp();
    test_preempt();
    test_reset_mid();
    test_abandon();
    test_ovr_track();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
